// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares the L1 data memory between CPU load/store and DMA bursts,
// with a bounded wait before DMA is force-granted over a busy CPU.
module data_mem_arbiter #(
  parameter int DATA_ADDR_WIDTH = 32,
  parameter int LEN_WIDTH = 8,
  parameter int NUM_WORDS = 128,
  parameter int MAX_WAIT = 16
) (
  input  logic                       cpu_clk,
  input  logic                       cpu_rst,
  input  logic                       cpu_mem_req,
  input  logic                       cpu_mem_write,
  output logic                       cpu_stall,
  input  logic                       dma_req,
  input  logic                       dma_dir,
  input  logic [DATA_ADDR_WIDTH-1:0] dma_base_addr,
  input  logic [LEN_WIDTH-1:0]       dma_len,
  output logic                       dma_grant,
  input  logic                       dma_beat_valid,
  output logic                       dma_beat,
  output logic                       dma_done,
  output logic [DATA_ADDR_WIDTH-1:0] dma_data_mem_raddr,
  output logic [DATA_ADDR_WIDTH-1:0] dma_data_mem_waddr,
  output logic                       data_mem_read_ctrl_by,
  output logic                       data_mem_write_ctrl_by,
  output logic                       data_mem_write
);
  localparam int WW = $clog2(MAX_WAIT) + 1;
  localparam logic [DATA_ADDR_WIDTH-1:0] NW = DATA_ADDR_WIDTH'(NUM_WORDS);
  localparam logic [DATA_ADDR_WIDTH-1:0] LAST = DATA_ADDR_WIDTH'(NUM_WORDS - 1);
  typedef enum logic [1:0] {IDLE, ARB, BURST, DONE} state_t;
  state_t state_q, state_d;
  logic dir_q, dir_d;
  logic [DATA_ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0] remaining_q, remaining_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic burst;
  always_ff @(posedge cpu_clk) begin
    if (cpu_rst) begin
      state_q <= IDLE;
      dir_q <= 1'b0;
      cur_addr_q <= '0;
      remaining_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      dir_q <= dir_d;
      cur_addr_q <= cur_addr_d;
      remaining_q <= remaining_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    dir_d = dir_q;
    cur_addr_d = cur_addr_q;
    remaining_d = remaining_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      IDLE: if (dma_req) begin
        state_d = ARB;
        dir_d = dma_dir;
        cur_addr_d = dma_base_addr % NW;
        remaining_d = dma_len;
        wait_cnt_d = '0;
      end
      ARB: begin
        if (remaining_q == '0) state_d = DONE;
        else if (!cpu_mem_req || wait_cnt_q == WW'(MAX_WAIT - 1)) state_d = BURST;
        else wait_cnt_d = wait_cnt_q + WW'(1);
      end
      BURST: if (dma_beat_valid) begin
        cur_addr_d = (cur_addr_q == LAST) ? '0 : cur_addr_q + DATA_ADDR_WIDTH'(1);
        remaining_d = remaining_q - LEN_WIDTH'(1);
        if (remaining_q == LEN_WIDTH'(1)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end
  assign burst = (state_q == BURST);
  assign dma_grant = burst;
  assign data_mem_read_ctrl_by = burst;
  assign data_mem_write_ctrl_by = burst;
  assign cpu_stall = burst & cpu_mem_req;
  assign dma_beat = burst & dma_beat_valid;
  assign dma_done = (state_q == DONE);
  assign data_mem_write = burst ? (dir_q & dma_beat_valid) : (cpu_mem_req & cpu_mem_write);
  assign dma_data_mem_raddr = cur_addr_q;
  assign dma_data_mem_waddr = cur_addr_q;
endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb_data_mem_arbiter: randomized transfers checked against a transaction-level reference.
module tb_data_mem_arbiter;
  localparam int AW = 32;
  localparam int LW = 8;
  localparam int NUM_WORDS = 128;
  localparam int MAX_WAIT = 16;
  logic cpu_clk, cpu_rst, cpu_mem_req, cpu_mem_write, cpu_stall;
  logic dma_req, dma_dir, dma_grant, dma_beat_valid, dma_beat, dma_done;
  logic [AW-1:0] dma_base_addr, dma_data_mem_raddr, dma_data_mem_waddr;
  logic [LW-1:0] dma_len;
  logic data_mem_read_ctrl_by, data_mem_write_ctrl_by, data_mem_write;
  int checks = 0;
  int failures = 0;
  bit exp_dir;
  data_mem_arbiter #(.DATA_ADDR_WIDTH(AW), .LEN_WIDTH(LW), .NUM_WORDS(NUM_WORDS), .MAX_WAIT(MAX_WAIT)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst), .cpu_mem_req(cpu_mem_req), .cpu_mem_write(cpu_mem_write),
    .cpu_stall(cpu_stall), .dma_req(dma_req), .dma_dir(dma_dir), .dma_base_addr(dma_base_addr),
    .dma_len(dma_len), .dma_grant(dma_grant), .dma_beat_valid(dma_beat_valid), .dma_beat(dma_beat),
    .dma_done(dma_done), .dma_data_mem_raddr(dma_data_mem_raddr), .dma_data_mem_waddr(dma_data_mem_waddr),
    .data_mem_read_ctrl_by(data_mem_read_ctrl_by), .data_mem_write_ctrl_by(data_mem_write_ctrl_by),
    .data_mem_write(data_mem_write)
  );
  initial cpu_clk = 0;
  always #5 cpu_clk = ~cpu_clk;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge cpu_clk);
    #1;
  endtask
  task automatic check_out(input string t, input bit b, input bit d);
    @(negedge cpu_clk);
    chk({t, ":grant"}, dma_grant, b);
    chk({t, ":rd_by"}, data_mem_read_ctrl_by, b);
    chk({t, ":wr_by"}, data_mem_write_ctrl_by, b);
    chk({t, ":stall"}, cpu_stall, b & cpu_mem_req);
    chk({t, ":beat"}, dma_beat, b & dma_beat_valid);
    chk({t, ":done"}, dma_done, d);
    chk({t, ":write"}, data_mem_write, b ? (exp_dir & dma_beat_valid) : (cpu_mem_req & cpu_mem_write));
  endtask
  task automatic drive_cpu(input int mode, input int k);
    cpu_mem_req = (mode == 0) ? 1'b0 : (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom) : (k < 3);
    cpu_mem_write = 1'($urandom);
  endtask
  // cmode: 0 idle, 1 always busy, 2 random, 3 busy for three ARB cycles
  // bmode: 0 beat every cycle, 1 random gaps, 2 two-cycle gap after the second beat
  task automatic run_xfer(input bit dir, input int unsigned base, input int len, input int cmode,
                          input int bmode, input int abort);
    int w = 0;
    int beats = 0;
    int g = 0;
    int unsigned a0 = base % NUM_WORDS;
    bit last;
    exp_dir = dir;
    dma_req = 1;
    dma_dir = dir;
    dma_base_addr = base;
    dma_len = LW'(len);
    dma_beat_valid = 1'($urandom);
    drive_cpu(cmode, 0);
    check_out("idle", 0, 0);
    tick;
    dma_dir = 1'($urandom);
    dma_base_addr = $urandom;
    dma_len = LW'($urandom);
    while (1) begin
      dma_req = 1'($urandom);
      dma_beat_valid = 1'($urandom);
      drive_cpu(cmode, w);
      check_out("arb", 0, 0);
      last = (len == 0) || !cpu_mem_req || (w == MAX_WAIT - 1);
      tick;
      if (last) break;
      w++;
    end
    while (beats < len) begin
      dma_req = 1'($urandom);
      drive_cpu(cmode, 100);
      dma_beat_valid = (bmode == 0) ? 1'b1 : (bmode == 1) ? ($urandom % 4 != 0) : !(beats == 2 && g < 2);
      if (bmode == 2 && beats == 2 && g < 2) g++;
      if (abort >= 0 && beats == abort) begin
        dma_beat_valid = 0;
        cpu_rst = 1;
        check_out("abort", 1, 0);
        tick;
        cpu_rst = 0;
        dma_req = 0;
        for (int i = 0; i < 3; i++) begin
          dma_beat_valid = 1'($urandom);
          drive_cpu(2, 0);
          check_out("post_rst", 0, 0);
          chk("post_rst:addr", dma_data_mem_raddr, 0);
          tick;
        end
        return;
      end
      check_out("burst", 1, 0);
      chk("burst:raddr", dma_data_mem_raddr, (a0 + beats) % NUM_WORDS);
      chk("burst:waddr", dma_data_mem_waddr, (a0 + beats) % NUM_WORDS);
      tick;
      if (dma_beat_valid) beats++;
    end
    dma_req = 0;
    dma_beat_valid = 1'($urandom);
    drive_cpu(2, 0);
    check_out("done", 0, 1);
    tick;
    drive_cpu(2, 0);
    check_out("idle2", 0, 0);
    tick;
  endtask
  initial begin
    cpu_rst = 1;
    cpu_mem_req = 0;
    cpu_mem_write = 0;
    dma_req = 0;
    dma_dir = 0;
    dma_base_addr = 0;
    dma_len = 0;
    dma_beat_valid = 0;
    exp_dir = 0;
    tick;
    tick;
    cpu_rst = 0;
    check_out("reset", 0, 0);
    chk("reset:addr", dma_data_mem_raddr, 0);
    tick;
    run_xfer(1, 10, 4, 0, 0, -1);
    run_xfer(0, 50, 2, 1, 0, -1);
    run_xfer(1, 5, 3, 3, 0, -1);
    run_xfer(1, 126, 4, 0, 0, -1);
    run_xfer(1, 7, 0, 2, 0, -1);
    run_xfer(0, 20, 5, 0, 2, -1);
    run_xfer(1, 30, 4, 0, 0, 2);
    run_xfer(1, 300, 20, 2, 1, -1);
    for (int n = 0; n < 40; n++)
      run_xfer(1'($urandom), $urandom, int'($urandom % 12), int'($urandom % 4), int'($urandom % 3),
               ($urandom % 8 == 0) ? 1 : -1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
